// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: funct codes,
// FSM state encoding and small decode helpers.
package muldiv_ctrl_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference when it did not borrow.
module muldiv_ctrl_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_dvd_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_rem,
  output logic         o_q_bit
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // Remainder stays below the divisor, so the shifted value fits in W+1 bits
  // and the top bit of the difference is a clean borrow flag.
  assign w_shift = {i_rem, i_dvd_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q_bit = ~w_diff[W];
  assign o_rem   = o_q_bit ? w_diff[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO. Define MULDIV_FAST_MUL_EN to replace
// the iterative shift-add multiplier with a single-cycle multiply.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  operand_a,
  input  logic [DATA_W-1:0]  operand_b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo,
  output logic [DATA_W-1:0]  mf_data,
  output state_t             dbg_state
);

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_hi, r_lo, r_op, r_rem, r_quo;
  logic [2*DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg, r_neg_r;

  logic                w_is_mul, w_is_div, w_b_zero, w_go, w_a_neg, w_b_neg;
  logic                w_last, w_mul_last, w_q_bit;
  logic [DATA_W-1:0]   w_a_abs, w_b_abs, w_rem_next, w_quo_next;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_acc_next, w_prod_mag, w_prod;

  assign w_is_mul   = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign w_is_div   = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign w_b_zero   = (operand_b == '0);
  assign w_go       = start && !flush;
  assign w_a_neg    = is_signed_op(funct) && operand_a[DATA_W-1];
  assign w_b_neg    = is_signed_op(funct) && operand_b[DATA_W-1];
  assign w_a_abs    = w_a_neg ? -operand_a : operand_a;
  assign w_b_abs    = w_b_neg ? -operand_b : operand_b;
  assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set, then shift right by one.
  assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, r_op & {DATA_W{r_acc[0]}}};
  assign w_acc_next = {w_sum, r_acc[DATA_W-1:1]};

`ifdef MULDIV_FAST_MUL_EN
  assign w_prod_mag = {{DATA_W{1'b0}}, r_op} * {{DATA_W{1'b0}}, r_acc[DATA_W-1:0]};
  assign w_mul_last = 1'b1;
`else
  assign w_prod_mag = w_acc_next;
  assign w_mul_last = w_last;
`endif
  assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;

  muldiv_ctrl_div_step #(.W(DATA_W)) u_div_step (
    .i_rem     (r_rem),
    .i_dvd_bit (r_quo[DATA_W-1]),
    .i_divisor (r_op),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );
  assign w_quo_next = {r_quo[DATA_W-2:0], w_q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go && w_is_mul) begin
          w_next = ST_MUL;
          busy   = 1'b1;
        end else if (w_go && w_is_div) begin
          w_next = w_b_zero ? ST_DONE : ST_DIV;
          busy   = !w_b_zero;
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (flush)           w_next = ST_IDLE;
        else if (w_mul_last) w_next = ST_DONE;
      end
      ST_DIV: begin
        busy = 1'b1;
        if (flush)       w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_go) begin
            if (w_is_mul) begin
              r_op  <= w_a_abs;
              r_acc <= {{DATA_W{1'b0}}, w_b_abs};
              r_neg <= w_a_neg ^ w_b_neg;
            end else if (w_is_div) begin
              r_op    <= w_b_abs;
              r_rem   <= '0;
              r_quo   <= w_a_abs;
              r_neg   <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end else if (funct == FUNCT_MTHI) begin
              r_hi <= operand_a;
            end else if (funct == FUNCT_MTLO) begin
              r_lo <= operand_a;
            end
          end
        end
        ST_MUL: begin
          if (!flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_mul_last) {r_hi, r_lo} <= w_prod;
          end
        end
        ST_DIV: begin
          if (!flush) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_lo <= r_neg ? -w_quo_next : w_quo_next;
              r_hi <= r_neg_r ? -w_rem_next : w_rem_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;
  assign mf_data   = (funct == FUNCT_MFHI) ? r_hi :
                     (funct == FUNCT_MFLO) ? r_lo : '0;

endmodule
